ej32_rs_unit: RTL and testbench

//   Return-stack unit: the far end of the data-stack <-> return-stack transfers.

---
 rtl/ej32_pkg.sv | 16 +
 rtl/bram_dp.sv | 26 ++
 rtl/ej32_rs_unit.sv | 116 +++++++++++
 tb/tb_ej32_rs_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ej32_pkg.sv
// Shared types and defaults for the ej32 return-stack unit.
package ej32_pkg;

  localparam int unsigned RS_DEPTH_DEF = 32;
  localparam int unsigned DSZ_DEF      = 32;
  localparam int unsigned RAM_AW       = 6;

  typedef enum logic [2:0] {
    rNOP  = 3'd0,
    rPUSH = 3'd1,
    rPOP  = 3'd2,
    rDEC  = 3'd3,
    rSET  = 3'd4
  } rs_op_t;

endpackage

// File: rtl/bram_dp.sv
// Simple dual-port EBR model: one synchronous write port, one registered read port.
module bram_dp #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          wr_clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge wr_clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge rd_clk_i) begin
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/ej32_rs_unit.sv
// Return-stack unit: top entry in register r, deeper entries in EBR clocked on ~clk
// so the next-below entry is already read out by the time the posedge pops it.
module ej32_rs_unit
  import ej32_pkg::*;
#(
  parameter  int unsigned RS_DEPTH = RS_DEPTH_DEF,
  parameter  int unsigned DSZ      = DSZ_DEF,
  localparam int unsigned DPW      = $clog2(RS_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rs_en,
  input  logic [2:0]     rs_op,
  input  logic [DSZ-1:0] d_i,
  output logic [DSZ-1:0] r_o,
  output logic [DPW-1:0] depth_o,
  output logic           zero_o,
  output logic           ovf_o,
  output logic           udf_o
);

  logic [DSZ-1:0]    r_q, r_nx;
  logic [DPW-1:0]    depth_q, depth_nx;
  logic              zero_q, ovf_q, ovf_nx, udf_q, udf_nx;
  logic              wr_en;
  logic [DPW-1:0]    wr_idx, rd_idx;
  logic [RAM_AW-1:0] wr_addr, rd_addr;
  logic [DSZ-1:0]    rd_data;
  logic              ram_clk;

  // Write slot is just below r; read slot is the entry a pop would promote.
  assign wr_idx  = depth_q - DPW'(1);
  assign rd_idx  = depth_q - DPW'(2);
  assign wr_addr = RAM_AW'(wr_idx);
  assign rd_addr = RAM_AW'(rd_idx);
  assign ram_clk = ~clk;

  // Command decoder; unknown encodings and rs_en low fall through as hold.
  always_comb begin
    r_nx     = r_q;
    depth_nx = depth_q;
    ovf_nx   = ovf_q;
    udf_nx   = udf_q;
    wr_en    = 1'b0;
    if (rs_en) begin
      case (rs_op_t'(rs_op))
        rPUSH: begin
          if (depth_q < DPW'(RS_DEPTH)) begin
            wr_en    = (depth_q != '0);
            r_nx     = d_i;
            depth_nx = depth_q + DPW'(1);
          end else begin
            ovf_nx = 1'b1;
          end
        end
        rPOP: begin
          if (depth_q == '0) begin
            udf_nx = 1'b1;
          end else begin
            r_nx     = (depth_q == DPW'(1)) ? '0 : rd_data;
            depth_nx = depth_q - DPW'(1);
          end
        end
        rDEC: begin
          if (depth_q == '0) udf_nx = 1'b1;
          else               r_nx   = r_q - DSZ'(1);
        end
        rSET: begin
          if (depth_q == '0) udf_nx = 1'b1;
          else               r_nx   = d_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= '0;
      depth_q <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      r_q     <= r_nx;
      depth_q <= depth_nx;
      zero_q  <= (depth_nx != '0) && (r_nx == '0);
      ovf_q   <= ovf_nx;
      udf_q   <= udf_nx;
    end
  end

  bram_dp #(
    .AW (RAM_AW),
    .DW (DSZ)
  ) u_ram (
    .wr_clk_i  (ram_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (r_q),
    .rd_clk_i  (ram_clk),
    .rd_en_i   (1'b1),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  a_no_ram_conflict: assert property (@(posedge clk) disable iff (rst)
    wr_en |-> (wr_addr != rd_addr));

  assign r_o     = r_q;
  assign depth_o = depth_q;
  assign zero_o  = zero_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: tb/tb_ej32_rs_unit.sv
// Directed self-checking bench for ej32_rs_unit.
module tb_ej32_rs_unit;
  import ej32_pkg::*;

  logic        clk;
  logic        rst;
  logic        rs_en;
  logic [2:0]  rs_op;
  logic [31:0] d_i;
  logic [31:0] r_o;
  logic [5:0]  depth_o;
  logic        zero_o;
  logic        ovf_o;
  logic        udf_o;

  int checks = 0;
  int errors = 0;

  ej32_rs_unit dut (
    .clk     (clk),
    .rst     (rst),
    .rs_en   (rs_en),
    .rs_op   (rs_op),
    .d_i     (d_i),
    .r_o     (r_o),
    .depth_o (depth_o),
    .zero_o  (zero_o),
    .ovf_o   (ovf_o),
    .udf_o   (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op for one cycle, then settle just after the edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] d);
    rs_en = 1'b1;
    rs_op = op;
    d_i   = d;
    @(posedge clk);
    #1;
    rs_op = 3'(rNOP);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rs_en = 1'b0;
    rs_op = 3'(rNOP);
    d_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_r", r_o, 32'd0);
    check("rst_depth", 32'(depth_o), 32'd0);
    check("rst_flags", {29'd0, zero_o, ovf_o, udf_o}, 32'd0);

    // 1. basic push/pop
    do_op(3'(rPUSH), 32'd11);
    do_op(3'(rPUSH), 32'd22);
    do_op(3'(rPUSH), 32'd33);
    check("t1_r", r_o, 32'd33);
    check("t1_depth", 32'(depth_o), 32'd3);
    do_op(3'(rPOP), 32'd0);
    check("t1_pop1", r_o, 32'd22);
    do_op(3'(rPOP), 32'd0);
    check("t1_pop2", r_o, 32'd11);
    do_op(3'(rPOP), 32'd0);
    check("t1_pop3", r_o, 32'd0);
    check("t1_depth0", 32'(depth_o), 32'd0);
    check("t1_udf", 32'(udf_o), 32'd0);

    // 2. underflow is sticky
    do_op(3'(rPOP), 32'd0);
    check("t2_depth", 32'(depth_o), 32'd0);
    check("t2_r", r_o, 32'd0);
    check("t2_udf", 32'(udf_o), 32'd1);
    repeat (5) do_op(3'(rNOP), 32'd0);
    check("t2_udf_sticky", 32'(udf_o), 32'd1);

    // 3. fill, overflow, drain
    do_reset();
    for (int i = 1; i <= 32; i++) do_op(3'(rPUSH), 32'(i));
    check("t3_full", 32'(depth_o), 32'd32);
    check("t3_ovf_pre", 32'(ovf_o), 32'd0);
    do_op(3'(rPUSH), 32'd99);
    check("t3_ovf", 32'(ovf_o), 32'd1);
    check("t3_r", r_o, 32'd32);
    check("t3_depth", 32'(depth_o), 32'd32);
    for (int k = 1; k <= 32; k++) begin
      do_op(3'(rPOP), 32'd0);
      check("t3_drain", r_o, 32'(32 - k));
    end
    check("t3_empty", 32'(depth_o), 32'd0);
    check("t3_ovf_sticky", 32'(ovf_o), 32'd1);
    check("t3_udf", 32'(udf_o), 32'd0);

    // 4. decrement, zero test, wrap, set, empty rDEC
    do_reset();
    do_op(3'(rPUSH), 32'd2);
    check("t4_zero_init", 32'(zero_o), 32'd0);
    do_op(3'(rDEC), 32'd0);
    check("t4_dec1", r_o, 32'd1);
    check("t4_zero1", 32'(zero_o), 32'd0);
    do_op(3'(rDEC), 32'd0);
    check("t4_dec0", r_o, 32'd0);
    check("t4_zero0", 32'(zero_o), 32'd1);
    do_op(3'(rDEC), 32'd0);
    check("t4_wrap", r_o, 32'hFFFF_FFFF);
    check("t4_zero_wrap", 32'(zero_o), 32'd0);
    do_op(3'(rSET), 32'hCAFE_0001);
    check("t4_set", r_o, 32'hCAFE_0001);
    check("t4_set_depth", 32'(depth_o), 32'd1);
    do_op(3'(rPOP), 32'd0);
    check("t4_udf_clear", 32'(udf_o), 32'd0);
    do_op(3'(rDEC), 32'd0);
    check("t4_dec_empty_r", r_o, 32'd0);
    check("t4_dec_empty_udf", 32'(udf_o), 32'd1);
    do_reset();
    do_op(3'(rSET), 32'd7);
    check("t4_set_empty_r", r_o, 32'd0);
    check("t4_set_empty_udf", 32'(udf_o), 32'd1);

    // 5. alternating push/pop, disabled unit, unknown op
    do_reset();
    do_op(3'(rPUSH), 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        do_op(3'(rPUSH), 32'd7);
        check("t5_push", r_o, 32'd7);
      end else begin
        do_op(3'(rPOP), 32'd0);
        check("t5_pop", r_o, 32'd5);
      end
    end
    check("t5_r", r_o, 32'd5);
    check("t5_depth", 32'(depth_o), 32'd1);
    rs_en = 1'b0;
    rs_op = 3'(rPOP);
    @(posedge clk);
    #1;
    check("t5_dis_r", r_o, 32'd5);
    check("t5_dis_depth", 32'(depth_o), 32'd1);
    do_op(3'd7, 32'd42);
    check("t5_unk_r", r_o, 32'd5);
    check("t5_unk_depth", 32'(depth_o), 32'd1);

    // 6. reset wins over a presented push
    do_op(3'(rPUSH), 32'd8);
    do_op(3'(rPUSH), 32'd9);
    do_op(3'(rPOP), 32'd0);
    do_op(3'(rPOP), 32'd0);
    do_op(3'(rPOP), 32'd0);
    do_op(3'(rPOP), 32'd0);
    check("t6_udf_set", 32'(udf_o), 32'd1);
    do_op(3'(rPUSH), 32'd1);
    do_op(3'(rPUSH), 32'd2);
    do_op(3'(rPUSH), 32'd3);
    check("t6_depth3", 32'(depth_o), 32'd3);
    rst   = 1'b1;
    rs_en = 1'b1;
    rs_op = 3'(rPUSH);
    d_i   = 32'd77;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rs_op = 3'(rNOP);
    check("t6_depth", 32'(depth_o), 32'd0);
    check("t6_r", r_o, 32'd0);
    check("t6_flags", {29'd0, zero_o, ovf_o, udf_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
